// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
//   Receive-side sequencer for the serial port. It runs on the 16x-data-rate
//   clock. It detects and validates start bits and shifts in data bits
//   LSB-first. It checks the stop bit and hands each word to the consumer
//   through a valid/ack handshake, with framing-error and overrun reporting.
//
// Ports
//   clk           in   16x data-rate clock
//   rst           in   asynchronous active-high reset
//   rx_in         in   raw serial line (idles high, asynchronous to clk)
//   rx_ack        in   consumer has taken rx_data
//   enable        out  high while a frame is in progress
//   frameProgress out  current bit index of the frame, 0..FRAME_WIDTH-1
//   endFrame      out  one-cycle pulse on the stop-bit sample edge
//   rx_data       out  last completed word, LSB = first data bit received
//   rx_valid      out  rx_data holds an unacknowledged word
//   frame_err     out  last completed frame had a zero stop bit
//   overrun       out  sticky; a good word overwrote an unacknowledged word
module rx_frame_ctrl #(
  parameter int FRAME_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic                   rx_ack,
  output logic                   enable,
  output logic [3:0]             frameProgress,
  output logic                   endFrame,
  output logic [FRAME_WIDTH-3:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int DATA_BITS = FRAME_WIDTH - 2;
  localparam int BCW       = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, sync3_q;
  logic [3:0]             sampleCnt_q, sampleCnt_d;
  logic [BCW-1:0]         bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   endFrame_q, endFrame_d;
  logic [DATA_BITS-1:0]   rxData_q, rxData_d;
  logic                   rxValid_q, rxValid_d;
  logic                   frameErr_q, frameErr_d;
  logic                   overrun_q, overrun_d;
  logic                   fallEdge;

  // Two-flop synchronizer plus a third copy for edge detection. All flops
  // reset high so that reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fallEdge = sync3_q & ~sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      endFrame_q  <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      endFrame_q  <= endFrame_d;
      rxData_q    <= rxData_d;
      rxValid_q   <= rxValid_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q + 4'd1;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    endFrame_d  = 1'b0;
    rxData_d    = rxData_q;
    rxValid_d   = rxValid_q;
    frameErr_d  = frameErr_q;
    overrun_d   = overrun_q;

    // An ack only counts when there is a word to take. A good frame
    // finishing on the same edge overrides rx_valid below.
    if (rx_ack && rxValid_q) begin
      rxValid_d = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        sampleCnt_d = '0;
        if (fallEdge) state_d = START;
      end
      START: begin
        // Mid-start-bit check. If the line is high, this was a glitch.
        if (sampleCnt_q == 4'd7) begin
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            sampleCnt_d = '0;
            bitCnt_d    = '0;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        // The counter was realigned to mid-bit, so each wrap is a bit centre.
        if (sampleCnt_q == 4'd15) begin
          shift_d  = {sync2_q, shift_q[DATA_BITS-1:1]};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == BCW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Return to IDLE mid-stop-bit so the next start edge is not missed.
        if (sampleCnt_q == 4'd15) begin
          endFrame_d = 1'b1;
          state_d    = IDLE;
          if (sync2_q) begin
            rxData_d   = shift_q;
            rxValid_d  = 1'b1;
            frameErr_d = 1'b0;
            if (rxValid_q && !rx_ack) overrun_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frameProgress = 4'd0;
    case (state_q)
      DATA:    frameProgress = 4'(bitCnt_q) + 4'd1;
      STOP:    frameProgress = 4'(FRAME_WIDTH - 1);
      default: frameProgress = 4'd0;
    endcase
  end

  assign enable    = (state_q != IDLE);
  assign endFrame  = endFrame_q;
  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule
